// File: rtl/tis_port_ctrl_pkg.sv
// Shared types and helpers for the TIS-100 node port sequencer.
// Operand codes, sequencer states and the direction-set decode.
package tis_port_ctrl_pkg;

    localparam int WORD_SIZE_DEFAULT = 11;

    // Port codes sit at 2..5 so that (code - 2) is the direction index.
    typedef enum logic [2:0] {
        SRC_NIL   = 3'd0,
        SRC_ACC   = 3'd1,
        SRC_LEFT  = 3'd2,
        SRC_RIGHT = 3'd3,
        SRC_UP    = 3'd4,
        SRC_DOWN  = 3'd5,
        SRC_ANY   = 3'd6,
        SRC_LAST  = 3'd7
    } src_t;

    typedef logic [1:0] dir_idx_t;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_RD   = 2'd1,
        PS_WR   = 2'd2,
        PS_DONE = 2'd3
    } port_state_t;

    function automatic logic src_is_port(src_t s);
        return (s >= SRC_LEFT);
    endfunction

    // LAST without a recorded direction yields an empty set, which the
    // sequencer treats as "complete immediately without a handshake".
    function automatic logic [3:0] src_to_mask(src_t s, dir_idx_t last_dir, logic last_valid);
        logic [3:0] m;
        m = 4'b0000;
        case (s)
            SRC_LEFT:  m = 4'b0001;
            SRC_RIGHT: m = 4'b0010;
            SRC_UP:    m = 4'b0100;
            SRC_DOWN:  m = 4'b1000;
            SRC_ANY:   m = 4'b1111;
            SRC_LAST:  if (last_valid) m = 4'b0001 << last_dir;
            default:   m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tis_port_ctrl_dir_prio.sv
// Fixed-priority picker over the four link directions: LEFT wins over
// RIGHT over UP over DOWN. Produces a one-hot grant and its index.
module tis_dir_prio
    import tis_port_ctrl_pkg::*;
(
    input  logic [3:0] req,
    output logic [3:0] grant,
    output dir_idx_t   idx,
    output logic       hit
);

    always_comb begin
        grant = 4'b0000;
        idx   = 2'd0;
        hit   = 1'b0;
        casez (req)
            4'b???1: begin grant = 4'b0001; idx = 2'd0; hit = 1'b1; end
            4'b??10: begin grant = 4'b0010; idx = 2'd1; hit = 1'b1; end
            4'b?100: begin grant = 4'b0100; idx = 2'd2; hit = 1'b1; end
            4'b1000: begin grant = 4'b1000; idx = 2'd3; hit = 1'b1; end
            default: begin grant = 4'b0000; idx = 2'd0; hit = 1'b0; end
        endcase
    end

endmodule

// File: rtl/tis_port_ctrl.sv
// Port side of one MOV-class transfer: optional blocking read from a link,
// optional blocking write to a link, with ANY/LAST direction resolution.
module tis_port_ctrl
    import tis_port_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  src_t                      src,
    input  src_t                      dst,
    input  logic [WORD_SIZE-1:0]      imm,
    output logic                      busy,
    output logic                      done,
    output logic [WORD_SIZE-1:0]      res_data,
    input  logic [3:0]                in_valid,
    input  logic [3:0][WORD_SIZE-1:0] in_data,
    output logic [3:0]                in_ack,
    output logic [3:0]                out_valid,
    output logic [WORD_SIZE-1:0]      out_data,
    input  logic [3:0]                out_take,
    output logic [3:0]                out_ack,
    output dir_idx_t                  last_dir,
    output logic                      last_valid
);

    port_state_t          state, state_nxt;
    logic [WORD_SIZE-1:0] value, value_nxt;
    src_t                 src_q, src_nxt;
    src_t                 dst_q, dst_nxt;
    dir_idx_t             last_dir_nxt;
    logic                 last_valid_nxt;

    logic [3:0] rd_mask, wr_mask;
    logic [3:0] rd_grant, wr_grant;
    dir_idx_t   rd_idx, wr_idx;
    logic       rd_hit, wr_hit;

    // Target sets follow the live LAST record, so a read under ANY can
    // steer a LAST write later in the same operation.
    assign rd_mask = src_to_mask(src_q, last_dir, last_valid);
    assign wr_mask = src_to_mask(dst_q, last_dir, last_valid);

    tis_dir_prio u_rd_prio (
        .req   (in_valid & rd_mask),
        .grant (rd_grant),
        .idx   (rd_idx),
        .hit   (rd_hit)
    );

    tis_dir_prio u_wr_prio (
        .req   (out_take & wr_mask),
        .grant (wr_grant),
        .idx   (wr_idx),
        .hit   (wr_hit)
    );

    assign busy = (state != PS_IDLE);

    always_comb begin
        state_nxt      = state;
        value_nxt      = value;
        src_nxt        = src_q;
        dst_nxt        = dst_q;
        last_dir_nxt   = last_dir;
        last_valid_nxt = last_valid;
        in_ack         = 4'b0000;
        out_valid      = 4'b0000;
        out_ack        = 4'b0000;
        out_data       = '0;
        done           = 1'b0;
        res_data       = '0;

        case (state)
            PS_IDLE: begin
                if (req) begin
                    src_nxt = src;
                    dst_nxt = dst;
                    if (src_is_port(src)) begin
                        state_nxt = PS_RD;
                    end else if (src_is_port(dst)) begin
                        value_nxt = imm;
                        state_nxt = PS_WR;
                    end else begin
                        value_nxt = imm;
                        state_nxt = PS_DONE;
                    end
                end
            end

            PS_RD: begin
                in_ack = rd_grant;
                if (rd_hit) begin
                    value_nxt = in_data[rd_idx];
                    if (src_q == SRC_ANY) begin
                        last_dir_nxt   = rd_idx;
                        last_valid_nxt = 1'b1;
                    end
                    state_nxt = src_is_port(dst_q) ? PS_WR : PS_DONE;
                end else if (rd_mask == 4'b0000) begin
                    // Unresolved LAST reads as zero without blocking.
                    value_nxt = '0;
                    state_nxt = src_is_port(dst_q) ? PS_WR : PS_DONE;
                end
            end

            PS_WR: begin
                out_valid = wr_mask;
                out_data  = value;
                out_ack   = wr_grant;
                if (wr_hit) begin
                    if (dst_q == SRC_ANY) begin
                        last_dir_nxt   = wr_idx;
                        last_valid_nxt = 1'b1;
                    end
                    state_nxt = PS_DONE;
                end else if (wr_mask == 4'b0000) begin
                    state_nxt = PS_DONE;
                end
            end

            PS_DONE: begin
                done      = 1'b1;
                res_data  = value;
                state_nxt = PS_IDLE;
            end

            default: state_nxt = PS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PS_IDLE;
            value      <= '0;
            src_q      <= SRC_NIL;
            dst_q      <= SRC_NIL;
            last_dir   <= 2'd0;
            last_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            value      <= value_nxt;
            src_q      <= src_nxt;
            dst_q      <= dst_nxt;
            last_dir   <= last_dir_nxt;
            last_valid <= last_valid_nxt;
        end
    end

endmodule
